hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, taken-branch flush and load-use stall.
// Define HAZARD_STATS_EN to add the saturating stall_cycles counter output.
module hazard_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_hold,
    output logic        if_hold,
    output logic        if_flush,
    output logic        ex_bubble,
    output logic        pipe_freeze,
    output logic        mem_timeout,
`ifdef HAZARD_STATS_EN
    output logic [31:0] stall_cycles,
`endif
    output logic [1:0]  state
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;
    logic       timeout_hit;
    logic       freeze_c;
    logic       lu;

    // Handshake: mem_req marks an outstanding MEM access; mem_ready completes it in the same cycle.
    assign timeout_hit = (state_q == S_WAIT) && (wait_cnt_q == WAIT_LAST) && !mem_ready;
    assign freeze_c    = ((state_q == S_RUN) && mem_req && !mem_ready)
                       || ((state_q == S_WAIT) && !mem_ready && !timeout_hit);
    assign lu = ex_mem_read && (ex_rd != 5'd0)
             && ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = S_RUN;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q | timeout_hit;
        case (state_q)
            S_RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 8'd0;
                end else if (branch_taken && !freeze_c) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_WAIT: begin
                // Saturate so a long wait can never wrap back into range.
                if (wait_cnt_q != 8'hFF) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
                state_d = (mem_ready || timeout_hit) ? S_RUN : S_WAIT;
            end
            S_FLUSH: begin
                state_d = branch_taken ? S_FLUSH : S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    // Output logic: freeze beats branch beats load-use
    always_comb begin
        pc_hold   = 1'b0;
        if_hold   = 1'b0;
        if_flush  = 1'b0;
        ex_bubble = 1'b0;
        if (freeze_c) begin
            pc_hold = 1'b1;
            if_hold = 1'b1;
        end else if (branch_taken) begin
            if_flush  = 1'b1;
            ex_bubble = 1'b1;
        end else if (lu) begin
            pc_hold   = 1'b1;
            if_hold   = 1'b1;
            ex_bubble = 1'b1;
        end
    end

    assign pipe_freeze = freeze_c;
    assign mem_timeout = mem_timeout_q;
    assign state       = state_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (pc_hold && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
